control_time_set: RTL and testbench
===================================

// Module: control_time_set
// PURPOSE
//  Front-panel input side of the clock/calendar: turns raw MODE/UP/DOWN pushbuttons into the
//  control vectors the counter/display datapath consumes (per-field inc/dec pulses, counter
//  enables, display blanking, 1 s tick enable). Sits between board buttons and the clock top.
//  Field index everywhere: 0=s 1=mi 2=h 3=d 4=mo 5=y.
// PARAMETERS
//  DEBOUNCE_CYCLES    500000    clocks a synced button must be stable before accepted (10 ms @50 MHz)
//  BLINK_HALF_CYCLES  25000000  half-period of selected-field blink (0.5 s)
//  REPEAT_DELAY       50000000  hold time before UP/DOWN auto-repeat starts (1 s)
//  REPEAT_RATE        10000000  clocks between auto-repeat pulses (0.2 s)
//  IDLE_TIMEOUT       500000000 clocks with no accepted press in a SET state before return to RUN (10 s)
// PORTS
//  clk                 in   1  system clock
//  rst                 in   1  asynchronous reset, active-high
//  btn_mode            in   1  raw MODE button, active-high, asynchronous
//  btn_up              in   1  raw UP button, active-high, asynchronous
//  btn_down            in   1  raw DOWN button, active-high, asynchronous
//  increase_signal     out  6  one-cycle increment pulse, one-hot on selected field
//  decrease_signal     out  6  one-cycle decrement pulse, one-hot on selected field
//  enable_cnt          out  6  per-field counter enable
//  enable_display      out  6  per-field display enable (0 = digits blanked)
//  enable_pulse_1s     out  1  1 = 1 s tick generator running
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. All outputs registered. Reset: state RUN,
//    inc/dec=6'h00, enable_cnt=6'h3F, enable_display=6'h3F, enable_pulse_1s=1, all timers 0.
//  - Each button: 2-FF synchroniser, then debounce counter; debounced level updates only after
//    DEBOUNCE_CYCLES consecutive equal samples; any change restarts count. Press = debounced 0->1.
//  - FSM: RUN -> SET_S -> SET_MI -> SET_H -> SET_D -> SET_MO -> SET_Y -> RUN, advance on MODE press.
//  - RUN: enable_cnt=6'h3F, enable_display=6'h3F, enable_pulse_1s=1; UP/DOWN ignored.
//  - SET_x: enable_pulse_1s=0; enable_cnt = one-hot bit x; enable_display = 6'h3F with bit x
//    driven by blink phase (1 visible, 0 blank). Phase and blink counter reset to visible/0 on
//    every SET-state entry; phase toggles every BLINK_HALF_CYCLES.
//  - UP press in SET_x: increase_signal[x]=1 for exactly 1 cycle, the cycle after the debounced
//    edge (latency 1 clk from debounced rise). DOWN likewise on decrease_signal[x].
//  - Auto-repeat: UP (or DOWN) held alone, REPEAT_DELAY clks after the press pulse emit first
//    repeat pulse, then one every REPEAT_RATE clks until release. Release clears repeat timer.
//  - UP and DOWN both debounced-high: no pulses, repeat timer held at 0; a later release of one
//    does not generate a press for the other (needs a fresh 0->1 edge).
//  - MODE press: state advances, any pending repeat cancelled, no inc/dec pulse that cycle even
//    if UP/DOWN edge coincides (MODE wins). Re-entering RUN restores RUN outputs next cycle.
//  - Idle timer counts in SET states, cleared on any press or repeat; at IDLE_TIMEOUT go to RUN.
//  - increase_signal and decrease_signal are never simultaneously nonzero; never nonzero in RUN.
//  - Reset mid-operation (mid-hold, mid-debounce, mid-blink) returns to reset values
//    immediately; a button still held after reset release produces no press until released
//    (debounced level initialises to 0 and requires stable-high then edge -> it counts as a press
//    only in SET states, which reset does not enter).
//  - Counter widths: ceil(log2(param+1)) bits each, saturate not wrap.
// STRUCTURE
//  - Shared include control_defs.vh: field index localparams (F_S..F_Y), FSM state encodings
//    (3-bit: RUN=0, SET_S=1 .. SET_Y=6), default timing constants.
//  - Sub-module control_debounce (sync + debounce + rising-edge strobe), instantiated 3x.
//  - FSM, blink timer, repeat timer, idle timer, output regs in this module.
// TESTING (bench params: DEBOUNCE=4, BLINK_HALF=8, REPEAT_DELAY=20, REPEAT_RATE=5, IDLE=100)
//  - Reset: assert rst async mid-cycle -> outputs 0/0/3F/3F/1 immediately, state RUN.
//  - Bounce: btn_mode toggling every 2 clks for 20 clks then high -> exactly one advance to
//    SET_S; enable_cnt=6'h01, enable_pulse_1s=0, enable_display[0] toggles every 8 clks.
//  - SET_H, UP held 60 clks -> one pulse on increase_signal[2], then pulses at +20,+25,+30..;
//    decrease_signal stays 0.
//  - SET_MO, UP and DOWN pressed same cycle -> no pulses; release UP, DOWN held -> still none.
//  - MODE x7 from RUN -> visits all 6 SET states, returns RUN with enable_cnt=6'h3F.
//  - SET_D idle 100 clks -> back to RUN, enable_display=6'h3F, enable_pulse_1s=1.

Source files
------------

// File: rtl/control_time_set_pkg.sv
// rtl/control_time_set_pkg.sv - field indices, FSM states, timing defaults and mask helpers
package control_time_set_pkg;

   localparam int F_S  = 0;
   localparam int F_MI = 1;
   localparam int F_H  = 2;
   localparam int F_D  = 3;
   localparam int F_MO = 4;
   localparam int F_Y  = 5;

   localparam logic [5:0] ALL_FIELDS = 6'h3F;

   localparam int DEF_DEBOUNCE_CYCLES   = 500000;
   localparam int DEF_BLINK_HALF_CYCLES = 25000000;
   localparam int DEF_REPEAT_DELAY      = 50000000;
   localparam int DEF_REPEAT_RATE       = 10000000;
   localparam int DEF_IDLE_TIMEOUT      = 500000000;

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      SET_S  = 3'd1,
      SET_MI = 3'd2,
      SET_H  = 3'd3,
      SET_D  = 3'd4,
      SET_MO = 3'd5,
      SET_Y  = 3'd6
   } state_t;

   function automatic state_t advance(input state_t s);
      case (s)
         RUN:     return SET_S;
         SET_S:   return SET_MI;
         SET_MI:  return SET_H;
         SET_H:   return SET_D;
         SET_D:   return SET_MO;
         SET_MO:  return SET_Y;
         default: return RUN;
      endcase
   endfunction

   function automatic logic [5:0] field_onehot(input state_t s);
      case (s)
         SET_S:   return 6'b1 << F_S;
         SET_MI:  return 6'b1 << F_MI;
         SET_H:   return 6'b1 << F_H;
         SET_D:   return 6'b1 << F_D;
         SET_MO:  return 6'b1 << F_MO;
         SET_Y:   return 6'b1 << F_Y;
         default: return 6'h00;
      endcase
   endfunction

   function automatic logic [5:0] cnt_mask(input state_t s);
      return (s == RUN) ? ALL_FIELDS : field_onehot(s);
   endfunction

   // Only the field being edited blinks; RUN has no selected field so it stays fully lit.
   function automatic logic [5:0] display_mask(input state_t s, input logic visible);
      return visible ? ALL_FIELDS : (ALL_FIELDS & ~field_onehot(s));
   endfunction

endpackage

// File: rtl/control_time_set_debounce.sv
// rtl/control_time_set_debounce.sv - button synchroniser, debouncer and press strobe
module control_time_set_debounce #(
   parameter int CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic rise
);

   localparam int W = $clog2(CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic          sync_a;
   logic          sync_b;
   logic [W-1:0]  cnt;

   // Level only follows the synced input after CYCLES consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         cnt    <= '0;
         level  <= 1'b0;
         rise   <= 1'b0;
      end else begin
         sync_a <= btn;
         sync_b <= sync_a;
         rise   <= 1'b0;
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt   <= '0;
            level <= sync_b;
            rise  <= sync_b;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/control_time_set.sv
// rtl/control_time_set.sv - front-panel MODE/UP/DOWN handling for the clock/calendar
module control_time_set
   import control_time_set_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int BLINK_HALF_CYCLES = DEF_BLINK_HALF_CYCLES,
   parameter int REPEAT_DELAY      = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE       = DEF_REPEAT_RATE,
   parameter int IDLE_TIMEOUT      = DEF_IDLE_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [5:0] increase_signal,
   output logic [5:0] decrease_signal,
   output logic [5:0] enable_cnt,
   output logic [5:0] enable_display,
   output logic       enable_pulse_1s
);

   localparam int BW   = $clog2(BLINK_HALF_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam int IW   = $clog2(IDLE_TIMEOUT + 1);

   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
   localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

   logic mode_level_unused;
   logic mode_rise;
   logic up_level;
   logic up_rise;
   logic down_level;
   logic down_rise;

   control_time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_mode),
      .level (mode_level_unused),
      .rise  (mode_rise)
   );

   control_time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_up),
      .level (up_level),
      .rise  (up_rise)
   );

   control_time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_down),
      .level (down_level),
      .rise  (down_rise)
   );

   state_t        state;
   logic [BW-1:0] blink_cnt;
   logic          phase;
   logic [RW-1:0] rep_cnt;
   logic          rep_armed;
   logic          rep_fast;
   logic [IW-1:0] idle_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= RUN;
         increase_signal <= 6'h00;
         decrease_signal <= 6'h00;
         enable_cnt      <= ALL_FIELDS;
         enable_display  <= ALL_FIELDS;
         enable_pulse_1s <= 1'b1;
         blink_cnt       <= '0;
         phase           <= 1'b1;
         rep_cnt         <= '0;
         rep_armed       <= 1'b0;
         rep_fast        <= 1'b0;
         idle_cnt        <= '0;
      end else begin
         increase_signal <= 6'h00;
         decrease_signal <= 6'h00;
         if (mode_rise) begin
            // MODE wins over a coincident UP/DOWN edge and drops any pending repeat.
            state           <= advance(state);
            enable_cnt      <= cnt_mask(advance(state));
            enable_display  <= ALL_FIELDS;
            enable_pulse_1s <= (advance(state) == RUN);
            blink_cnt       <= '0;
            phase           <= 1'b1;
            rep_cnt         <= '0;
            rep_armed       <= 1'b0;
            rep_fast        <= 1'b0;
            idle_cnt        <= '0;
         end else if (state == RUN || idle_cnt == IDLE_LAST) begin
            state           <= RUN;
            enable_cnt      <= ALL_FIELDS;
            enable_display  <= ALL_FIELDS;
            enable_pulse_1s <= 1'b1;
            blink_cnt       <= '0;
            phase           <= 1'b1;
            rep_cnt         <= '0;
            rep_armed       <= 1'b0;
            rep_fast        <= 1'b0;
            idle_cnt        <= '0;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt      <= '0;
               phase          <= ~phase;
               enable_display <= display_mask(state, ~phase);
            end else begin
               blink_cnt      <= blink_cnt + 1'b1;
               enable_display <= display_mask(state, phase);
            end

            if (up_level && down_level) begin
               rep_cnt   <= '0;
               rep_armed <= 1'b0;
               rep_fast  <= 1'b0;
            end else if (up_rise || down_rise) begin
               if (up_rise) increase_signal <= field_onehot(state);
               else         decrease_signal <= field_onehot(state);
               rep_cnt   <= '0;
               rep_armed <= 1'b1;
               rep_fast  <= 1'b0;
               idle_cnt  <= '0;
            end else if (rep_armed && (up_level || down_level)) begin
               // Long first gap (REPEAT_DELAY) then the shorter REPEAT_RATE cadence.
               if (rep_cnt == (rep_fast ? RATE_LAST : DELAY_LAST)) begin
                  if (up_level) increase_signal <= field_onehot(state);
                  else          decrease_signal <= field_onehot(state);
                  rep_cnt  <= '0;
                  rep_fast <= 1'b1;
                  idle_cnt <= '0;
               end else begin
                  rep_cnt <= rep_cnt + 1'b1;
               end
            end else begin
               rep_cnt   <= '0;
               rep_armed <= 1'b0;
               rep_fast  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_control_time_set.sv
// tb/tb_control_time_set.sv - directed self-checking bench for control_time_set
module tb_control_time_set;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic [5:0] increase_signal;
   logic [5:0] decrease_signal;
   logic [5:0] enable_cnt;
   logic [5:0] enable_display;
   logic       enable_pulse_1s;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   control_time_set #(
      .DEBOUNCE_CYCLES   (4),
      .BLINK_HALF_CYCLES (8),
      .REPEAT_DELAY      (20),
      .REPEAT_RATE       (5),
      .IDLE_TIMEOUT      (100)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .btn_mode        (btn_mode),
      .btn_up          (btn_up),
      .btn_down        (btn_down),
      .increase_signal (increase_signal),
      .decrease_signal (decrease_signal),
      .enable_cnt      (enable_cnt),
      .enable_display  (enable_display),
      .enable_pulse_1s (enable_pulse_1s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_mode;
      btn_mode = 1'b1;
      tick(10);
      btn_mode = 1'b0;
      tick(10);
   endtask

   task automatic wait_cnt(input string tag, input logic [5:0] exp, input int budget);
      int n = 0;
      while (enable_cnt !== exp && n < budget) begin
         tick(1);
         n++;
      end
      check(tag, 32'(enable_cnt), 32'(exp));
   endtask

   task automatic cycles_to_toggle(output int n);
      logic b;
      b = enable_display[0];
      n = 0;
      while (enable_display[0] == b && n < 30) begin
         tick(1);
         n++;
      end
   endtask

   task automatic count_pulses(input int n, output int hits);
      hits = 0;
      for (int i = 0; i < n; i++) begin
         tick(1);
         if (increase_signal != 6'h00 || decrease_signal != 6'h00) hits++;
      end
   endtask

   task automatic check_run_outputs(input string tag);
      check({tag, "_inc"},  32'(increase_signal), 32'h00);
      check({tag, "_dec"},  32'(decrease_signal), 32'h00);
      check({tag, "_cnt"},  32'(enable_cnt),      32'h3F);
      check({tag, "_disp"}, 32'(enable_display),  32'h3F);
      check({tag, "_1s"},   32'(enable_pulse_1s), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hits;
      int n;
      int times[$];
      int wrong_field;
      int dec_hits;
      int d0, d1, d2;
      logic [5:0] seq [7];

      seq[0] = 6'h01; seq[1] = 6'h02; seq[2] = 6'h04; seq[3] = 6'h08;
      seq[4] = 6'h10; seq[5] = 6'h20; seq[6] = 6'h3F;

      tick(3);
      check_run_outputs("reset_held");
      rst = 1'b0;
      tick(3);
      check_run_outputs("after_reset");

      // UP is ignored in RUN
      btn_up = 1'b1;
      count_pulses(30, hits);
      check("run_up_ignored", 32'(hits), 32'd0);
      btn_up = 1'b0;
      tick(10);

      // Bouncing MODE settles into exactly one advance
      for (int i = 0; i < 10; i++) begin
         btn_mode = ~btn_mode;
         tick(2);
      end
      btn_mode = 1'b1;
      wait_cnt("bounce_set_s", 6'h01, 20);
      check("set_s_1s", 32'(enable_pulse_1s), 32'h0);
      check("set_s_disp_entry", 32'(enable_display), 32'h3F);
      cycles_to_toggle(n);
      check("blink_first", 32'(n), 32'd8);
      check("blink_blank", 32'(enable_display), 32'h3E);
      cycles_to_toggle(n);
      check("blink_second", 32'(n), 32'd8);
      check("blink_visible", 32'(enable_display), 32'h3F);
      btn_mode = 1'b0;
      tick(10);
      check("bounce_single_adv", 32'(enable_cnt), 32'h01);

      press_mode();
      press_mode();
      check("set_h", 32'(enable_cnt), 32'h04);

      // Hold UP in SET_H: press, then +20, then every +5
      wrong_field = 0;
      dec_hits = 0;
      btn_up = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (increase_signal != 6'h00) begin
            times.push_back(i);
            if (increase_signal !== 6'h04) wrong_field++;
         end
         if (decrease_signal != 6'h00) dec_hits++;
      end
      btn_up = 1'b0;
      tick(12);
      d0 = (times.size() > 1) ? times[1] - times[0] : -1;
      d1 = (times.size() > 2) ? times[2] - times[1] : -1;
      d2 = (times.size() > 3) ? times[3] - times[2] : -1;
      check("hold_first_lat", 32'((times.size() > 0) && times[0] >= 3 && times[0] <= 8), 32'd1);
      check("hold_count", 32'(times.size() >= 6), 32'd1);
      check("hold_delay", 32'(d0), 32'd20);
      check("hold_rate1", 32'(d1), 32'd5);
      check("hold_rate2", 32'(d2), 32'd5);
      check("hold_field", 32'(wrong_field), 32'd0);
      check("hold_no_dec", 32'(dec_hits), 32'd0);

      press_mode();
      press_mode();
      check("set_mo", 32'(enable_cnt), 32'h10);

      // UP and DOWN together, then only DOWN left held
      btn_up = 1'b1;
      btn_down = 1'b1;
      count_pulses(20, hits);
      check("both_no_pulse", 32'(hits), 32'd0);
      btn_up = 1'b0;
      count_pulses(30, hits);
      check("down_left_no_pulse", 32'(hits), 32'd0);
      btn_down = 1'b0;
      tick(10);

      press_mode();
      check("set_y", 32'(enable_cnt), 32'h20);
      press_mode();
      check_run_outputs("wrap_run");

      // Full MODE cycle
      for (int i = 0; i < 7; i++) begin
         press_mode();
         check($sformatf("mode_seq%0d", i), 32'(enable_cnt), 32'(seq[i]));
         check($sformatf("mode_seq1s%0d", i), 32'(enable_pulse_1s), 32'(i == 6));
      end

      // Idle timeout from SET_D
      for (int i = 0; i < 4; i++) press_mode();
      check("set_d", 32'(enable_cnt), 32'h08);
      tick(66);
      check("idle_not_yet", 32'(enable_cnt), 32'h08);
      wait_cnt("idle_to_run", 6'h3F, 40);
      check("idle_disp", 32'(enable_display), 32'h3F);
      check("idle_1s", 32'(enable_pulse_1s), 32'h1);

      // Async reset mid-debounce of a held UP in SET_S
      press_mode();
      check("pre_rst_set_s", 32'(enable_cnt), 32'h01);
      btn_up = 1'b1;
      tick(3);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_run_outputs("async_rst");
      #2;
      tick(2);
      rst = 1'b0;
      tick(10);
      press_mode();
      check("post_rst_set_s", 32'(enable_cnt), 32'h01);
      count_pulses(30, hits);
      check("held_through_rst", 32'(hits), 32'd0);
      btn_up = 1'b0;
      tick(10);
      btn_up = 1'b1;
      count_pulses(12, hits);
      check("fresh_up_press", 32'(hits), 32'd1);
      btn_up = 1'b0;
      tick(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
